alu_req_arbiter: RTL

//  Shares one ALU datapath (calc/div/mult behind its go/done control unit) among NREQ clients.

---
 rtl/alu_req_arbiter_if.sv | 37 +++
 rtl/alu_req_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter_if.sv
// Bundle between alu_req_arbiter, its NREQ clients and the ALU datapath control unit.
// The arbiter takes the slave modport; the client/datapath side takes the master modport.
interface alu_req_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 4
);
  // Handshake: req[i] is a level a client holds until ack[i], a one-cycle pulse that
  // marks rsp_data/rsp_err valid for that client. dp_go is a one-cycle start pulse;
  // dp_done is a one-cycle completion pulse that qualifies dp_out/dp_err.
  logic [NREQ-1:0]   req;
  logic [3*NREQ-1:0] req_f;
  logic [W*NREQ-1:0] req_x;
  logic [W*NREQ-1:0] req_y;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   ack;
  logic [2*W-1:0]    rsp_data;
  logic              rsp_err;
  logic              busy;
  logic              dp_go;
  logic [2:0]        dp_f;
  logic [W-1:0]      dp_x;
  logic [W-1:0]      dp_y;
  logic              dp_done;
  logic              dp_err;
  logic [2*W-1:0]    dp_out;
  logic [1:0]        dbg_state;

  modport master (
    output req, req_f, req_x, req_y, dp_done, dp_err, dp_out,
    input  gnt, ack, rsp_data, rsp_err, busy, dp_go, dp_f, dp_x, dp_y, dbg_state
  );

  modport slave (
    input  req, req_f, req_x, req_y, dp_done, dp_err, dp_out,
    output gnt, ack, rsp_data, rsp_err, busy, dp_go, dp_f, dp_x, dp_y, dbg_state
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one go/done ALU datapath among NREQ clients.
// Optional WAIT timeout abort is compiled in with ARB_TIMEOUT_EN.
module alu_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 4,
  parameter int TIMEOUT = 63
) (
  input logic clk,
  input logic rst,
  alu_req_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;
  logic [IW-1:0] sel_idx;
  logic [IW-1:0] cand;
  logic          sel_found;
  logic [2:0]    f_sel;
  logic [W-1:0]  x_sel;
  logic [W-1:0]  y_sel;
  int            j;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_nxt;
  assign wait_cnt_nxt = wait_cnt + 8'd1;
`endif

  assign bus.dbg_state = state;

  // Scan ptr, ptr+1, ... wrapping at NREQ; the first pending request wins.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    cand      = '0;
    j         = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      cand = IW'(j);
      if (!sel_found && bus.req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    f_sel = '0;
    x_sel = '0;
    y_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel_idx == IW'(i)) begin
        f_sel = bus.req_f[3*i +: 3];
        x_sel = bus.req_x[W*i +: W];
        y_sel = bus.req_y[W*i +: W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      idx          <= '0;
      bus.gnt      <= '0;
      bus.ack      <= '0;
      bus.rsp_data <= '0;
      bus.rsp_err  <= 1'b0;
      bus.busy     <= 1'b0;
      bus.dp_go    <= 1'b0;
      bus.dp_f     <= '0;
      bus.dp_x     <= '0;
      bus.dp_y     <= '0;
`ifdef ARB_TIMEOUT_EN
      wait_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            idx       <= sel_idx;
            bus.dp_f  <= f_sel;
            bus.dp_x  <= x_sel;
            bus.dp_y  <= y_sel;
            bus.gnt   <= ONE << sel_idx;
            bus.dp_go <= 1'b1;
            bus.busy  <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          bus.dp_go <= 1'b0;
`ifdef ARB_TIMEOUT_EN
          wait_cnt  <= '0;
`endif
          state     <= WAIT;
        end
        WAIT: begin
          // A completion in the same cycle as the timeout takes precedence.
          if (bus.dp_done) begin
            bus.rsp_data <= bus.dp_out;
            bus.rsp_err  <= bus.dp_err;
            bus.ack      <= ONE << idx;
            state        <= RESP;
          end
`ifdef ARB_TIMEOUT_EN
          else if (wait_cnt_nxt == 8'(TIMEOUT)) begin
            bus.rsp_data <= '0;
            bus.rsp_err  <= 1'b1;
            bus.ack      <= ONE << idx;
            state        <= RESP;
          end else begin
            wait_cnt <= wait_cnt_nxt;
          end
`endif
        end
        RESP: begin
          bus.ack  <= '0;
          bus.gnt  <= '0;
          bus.busy <= 1'b0;
          ptr      <= (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
